uart_fifo_ctrl: RTL

- Bus-side front end for the serial UART core.
- Buffers CPU writes in a TX FIFO and drives the core's start/din handshake.
- Drains each received byte from the core (dout/has_byte/clr_hb) into an RX FIFO.
- Exposes data, status/interrupt-enable and a 16-bit baud divisor through a 4-register byte interface, and raises an interrupt line.

---
 rtl/uart_fifo_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: bus-side front end for the serial UART core.
//   CPU writes are queued in a TX FIFO and handed to the core over start/din.
//   Each received byte is drained from the core (dout/has_byte/clr_hb) into
//   an RX FIFO. Four byte registers expose data, status/irq-enable and the
//   16-bit baud divisor.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   addr/wdata/we   register select, write data, write strobe
//   re/rdata        read strobe, registered read data (valid cycle after re)
//   irq             level interrupt (RX not empty / TX empty, per ie)
//   divisor         baud divisor to the core
//   uart_din/uart_start          TX handshake to the core
//   uart_busy                    core transmitter busy
//   uart_dout/uart_has_byte      received byte from the core
//   uart_clr_hb                  acknowledge of the received byte
//
// TX FSM
//   state   | meaning
//   TX_IDLE | waiting for a queued byte and an idle core
//   TX_ARM  | start issued, waiting for the core to raise busy
//   TX_SEND | frame in progress, waiting for busy to fall
// RX FSM
//   state   | meaning
//   RX_WAIT | waiting for has_byte
//   RX_ACK  | clr_hb sent, waiting for has_byte to drop
module uart_fifo_ctrl #(
  parameter int          AW        = 3,
  parameter logic [15:0] DIV_RESET = 16'd103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  input  logic        re,
  output logic [7:0]  rdata,
  output logic        irq,
  output logic [15:0] divisor,
  output logic [7:0]  uart_din,
  output logic        uart_start,
  input  logic        uart_busy,
  input  logic [7:0]  uart_dout,
  input  logic        uart_has_byte,
  output logic        uart_clr_hb
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {TX_IDLE, TX_ARM, TX_SEND} tx_state_t;
  typedef enum logic       {RX_WAIT, RX_ACK}          rx_state_t;

  tx_state_t r_tx_state;
  rx_state_t r_rx_state;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp;
  logic [AW:0]   r_tx_cnt;
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wp, r_rx_rp;
  logic [AW:0]   r_rx_cnt;

  logic [1:0] r_ie;
  logic       r_overrun;

  logic w_tx_full, w_tx_nempty, w_rx_full, w_rx_nempty;
  logic w_tx_push, w_tx_pop, w_rx_pop, w_rx_take, w_rx_push;
  logic w_tx_active, w_tx_empty;
  logic [7:0] w_status;

  // Count never exceeds DEPTH, so its MSB is set exactly when full.
  assign w_tx_full   = r_tx_cnt[AW];
  assign w_tx_nempty = (r_tx_cnt != '0);
  assign w_rx_full   = r_rx_cnt[AW];
  assign w_rx_nempty = (r_rx_cnt != '0);

  assign w_tx_push = we && (addr == 2'd0) && !w_tx_full;
  assign w_tx_pop  = (r_tx_state == TX_IDLE) && w_tx_nempty && !uart_busy;
  assign w_rx_pop  = re && (addr == 2'd0) && w_rx_nempty;
  assign w_rx_take = (r_rx_state == RX_WAIT) && uart_has_byte;
  // A full FIFO being popped on the same edge still has room for the byte.
  assign w_rx_push = w_rx_take && (!w_rx_full || w_rx_pop);

  assign w_tx_active = (r_tx_state != TX_IDLE);
  assign w_tx_empty  = !w_tx_nempty && (r_tx_state == TX_IDLE);
  assign w_status    = {3'b000, r_overrun, w_tx_active, w_tx_empty, w_tx_full, w_rx_nempty};

  // FIFO storage carries no reset; only pointers and counts matter.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= uart_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;

      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      uart_din   <= 8'h00;
      uart_start <= 1'b0;
    end else begin
      uart_start <= 1'b0;
      case (r_tx_state)
        TX_IDLE: if (w_tx_pop) begin
          uart_din   <= r_tx_mem[r_tx_rp];
          uart_start <= 1'b1;
          r_tx_state <= TX_ARM;
        end
        // Busy lags start by two cycles; never restart while waiting for it.
        TX_ARM:  if (uart_busy)  r_tx_state <= TX_SEND;
        TX_SEND: if (!uart_busy) r_tx_state <= TX_IDLE;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state  <= RX_WAIT;
      uart_clr_hb <= 1'b0;
    end else begin
      uart_clr_hb <= 1'b0;
      case (r_rx_state)
        RX_WAIT: if (uart_has_byte) begin
          uart_clr_hb <= 1'b1;
          r_rx_state  <= RX_ACK;
        end
        RX_ACK:  if (!uart_has_byte) r_rx_state <= RX_WAIT;
        default: r_rx_state <= RX_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata     <= 8'h00;
      irq       <= 1'b0;
      divisor   <= DIV_RESET;
      r_ie      <= 2'b00;
      r_overrun <= 1'b0;
    end else begin
      if (we) begin
        case (addr)
          2'd1:    r_ie          <= wdata[1:0];
          2'd2:    divisor[7:0]  <= wdata;
          2'd3:    divisor[15:8] <= wdata;
          default: ;
        endcase
      end
      if (re) begin
        case (addr)
          2'd0:    rdata <= w_rx_nempty ? r_rx_mem[r_rx_rp] : 8'h00;
          2'd1:    rdata <= w_status;
          2'd2:    rdata <= divisor[7:0];
          default: rdata <= divisor[15:8];
        endcase
      end
      // Set is ordered after clear so a dropped byte is never lost to a status read.
      if (re && (addr == 2'd1))  r_overrun <= 1'b0;
      if (w_rx_take && !w_rx_push) r_overrun <= 1'b1;
      irq <= (r_ie[0] & w_rx_nempty) | (r_ie[1] & w_tx_empty);
    end
  end

endmodule
